// File: rtl/aes_cbc_unchain.sv
// aes_cbc_unchain
//   Downstream stage of the iterative AES decrypt core. Each inverse-cipher
//   result is XORed with the chaining value to recover the plaintext:
//     - the chaining value is the previous ciphertext block, or the IV for
//       the first block of a chain.
//   Plaintext blocks are buffered in a small FIFO and then serialised
//   MSB-first as OUT_W-bit words.
//
//   Optional feature: define AES_UNCHAIN_ECB_EN to add the ecb_mode input.
//   While ecb_mode=1 the XOR is bypassed. prev_ct still tracks every
//   accepted ciphertext block, so returning to CBC continues the chain.
//
// Parameters
//   OUT_W  output word width (8,16,32,64,128); W = 128/OUT_W words per block
//   DEPTH  plaintext FIFO depth in blocks (power of 2, >= 2)
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   iv_load, iv           load iv into the chaining register (restart chain)
//   ecb_mode              (AES_UNCHAIN_ECB_EN only) skip the CBC XOR
//   dec_valid, dec_ready  input handshake for dec_block / ct_block
//   dec_block, ct_block   inverse-cipher output and the ciphertext behind it
//   out_valid, out_ready  output word handshake
//   out_data              plaintext word, block bits [127:128-OUT_W] first
//   out_last              marks the final word of a block
module aes_cbc_unchain #(
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iv_load,
  input  logic [127:0]     iv,
`ifdef AES_UNCHAIN_ECB_EN
  input  logic             ecb_mode,
`endif
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [127:0]     dec_block,
  input  logic [127:0]     ct_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int W    = 128 / OUT_W;
  localparam int IDXW = (W > 1) ? $clog2(W) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [127:0]    prev_ct_r;
  logic [127:0]    mem_r [DEPTH];
  logic [PW-1:0]   wptr_r;
  logic [PW-1:0]   rptr_r;
  logic [CW-1:0]   count_r;
  logic [IDXW-1:0] idx_r;

  logic            accept_s;
  logic            xfer_s;
  logic            pop_s;
  logic            last_s;
  logic [127:0]    chain_s;
  logic [127:0]    push_data_s;
  logic [127:0]    head_s;

  // Handshake qualifiers and the unchained plaintext block.
  always_comb begin
    dec_ready = (count_r != CW'(DEPTH));
    out_valid = (count_r != {CW{1'b0}});
    accept_s  = dec_valid && dec_ready;
    chain_s   = iv_load ? iv : prev_ct_r;
`ifdef AES_UNCHAIN_ECB_EN
    if (ecb_mode) begin
      push_data_s = dec_block;
    end else begin
      push_data_s = dec_block ^ chain_s;
    end
`else
    push_data_s = dec_block ^ chain_s;
`endif
    head_s    = mem_r[rptr_r];
    last_s    = (idx_r == IDXW'(W - 1));
    xfer_s    = out_valid && out_ready;
    pop_s     = xfer_s && last_s;
  end

  // Serialiser view of the FIFO head; gated so an empty FIFO drives zeros.
  always_comb begin
    if (out_valid) begin
      out_data = head_s[127 - 32'(idx_r) * OUT_W -: OUT_W];
      out_last = last_s;
    end else begin
      out_data = {OUT_W{1'b0}};
      out_last = 1'b0;
    end
  end

  // Chaining register: an accept takes ct_block even when iv_load is also high,
  // because the iv has already been consumed by that block's XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ct_r <= 128'd0;
    end else if (accept_s) begin
      prev_ct_r <= ct_block;
    end else if (iv_load) begin
      prev_ct_r <= iv;
    end else begin
      prev_ct_r <= prev_ct_r;
    end
  end

  // FIFO storage; contents need no reset since reads are qualified by count_r.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wptr_r] <= push_data_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Word index within the head block; wraps to 0 on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {IDXW{1'b0}};
    end else if (xfer_s) begin
      if (last_s) begin
        idx_r <= {IDXW{1'b0}};
      end else begin
        idx_r <= idx_r + IDXW'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

endmodule

// File: tb/tb_aes_cbc_unchain.sv
// Directed testbench for aes_cbc_unchain (OUT_W=32, DEPTH=2).
// Inputs change and outputs are sampled on the falling edge.
module tb_aes_cbc_unchain;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iv_load = 1'b0;
  logic [127:0] iv = 128'd0;
  logic         dec_valid = 1'b0;
  logic         dec_ready;
  logic [127:0] dec_block = 128'd0;
  logic [127:0] ct_block = 128'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
`ifdef AES_UNCHAIN_ECB_EN
  logic         ecb_mode = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  aes_cbc_unchain #(.OUT_W(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iv_load   (iv_load),
    .iv        (iv),
`ifdef AES_UNCHAIN_ECB_EN
    .ecb_mode  (ecb_mode),
`endif
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_block (dec_block),
    .ct_block  (ct_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv_load = 1'b1;
    iv = v;
    step();
    iv_load = 1'b0;
  endtask

  // Present one block until it is taken (bounded wait on dec_ready).
  task automatic offer(input logic [127:0] d, input logic [127:0] c,
                       input logic ivl, input logic [127:0] ivv);
    int n;
    n = 0;
    while (!dec_ready && n < 20) begin
      step();
      n++;
    end
    chk("offer_ready", {127'd0, dec_ready}, 128'd1);
    dec_valid = 1'b1;
    dec_block = d;
    ct_block = c;
    iv_load = ivl;
    iv = ivv;
    step();
    dec_valid = 1'b0;
    iv_load = 1'b0;
  endtask

  // Drain one 4-word block with out_ready=1, checking word order and out_last.
  task automatic collect(input string tag, input logic [127:0] exp);
    logic [127:0] blk;
    int n;
    blk = 128'd0;
    out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
      chk({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
      chk({tag, "_last"}, {127'd0, out_last}, {127'd0, (w == 3)});
      blk = {blk[95:0], out_data};
      step();
    end
    out_ready = 1'b0;
    chk(tag, blk, exp);
  endtask

  logic [127:0] bp_dec [3];
  logic [127:0] bp_ct  [3];
  logic [127:0] ct1;
  int acc;

  initial begin
    // Reset state
    #1;
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_data", {96'd0, out_data}, 128'd0);
    chk("rst_last", {127'd0, out_last}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {127'd0, dec_ready}, 128'd1);

    // FIPS-197 block with a zero IV: words on consecutive cycles
    load_iv(128'd0);
    offer(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
          1'b0, 128'd0);
    collect("fips", 128'h00112233445566778899aabbccddeeff);
    chk("fips_empty", {127'd0, out_valid}, 128'd0);

    // SP800-38A CBC, two chained blocks
    ct1 = 128'h7649abac8119b246cee98e9b12e9197d;
    load_iv(128'h000102030405060708090a0b0c0d0e0f);
    offer(128'h6bc0bce12a459991e134741a7f9e1925, ct1, 1'b0, 128'd0);
    offer(128'hae2d8a571e03ac9c9eb76fac45af8e51 ^ ct1,
          128'h5086cb9b507219ee95db113a917678b2, 1'b0, 128'd0);
    collect("sp_blk1", 128'h6bc1bee22e409f96e93d7e117393172a);
    collect("sp_blk2", 128'hae2d8a571e03ac9c9eb76fac45af8e51);

    // Backpressure: three blocks offered back-to-back, only two fit
    bp_dec[0] = 128'h0123456789abcdef0011223344556677;
    bp_dec[1] = 128'hfedcba98765432108899aabbccddeeff;
    bp_dec[2] = 128'h13579bdf2468ace00f1e2d3c4b5a6978;
    bp_ct[0]  = 128'h11111111222222223333333344444444;
    bp_ct[1]  = 128'h5555555566666666777777778888aaaa;
    bp_ct[2]  = 128'h9999999900000000bbbbbbbbcccccccc;
    load_iv(128'd0);
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      dec_valid = 1'b1;
      dec_block = bp_dec[acc];
      ct_block = bp_ct[acc];
      if (dec_ready) acc++;
      step();
    end
    dec_valid = 1'b0;
    chk("bp_accepted", 128'(acc), 128'd2);
    chk("bp_full", {127'd0, dec_ready}, 128'd0);
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", {96'd0, out_data}, {96'd0, bp_dec[0][127:96]});
      step();
    end
    collect("bp_blk1", bp_dec[0]);
    chk("bp_ready_back", {127'd0, dec_ready}, 128'd1);
    offer(bp_dec[2], bp_ct[2], 1'b0, 128'd0);
    collect("bp_blk2", bp_dec[1] ^ bp_ct[0]);
    collect("bp_blk3", bp_dec[2] ^ bp_ct[1]);

    // iv_load coincident with an accept
    offer(128'd0, 128'hc0ffee00c0ffee00c0ffee00c0ffee00, 1'b1, {128{1'b1}});
    offer(128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 128'h1234, 1'b0, 128'd0);
    collect("sim_ivblk", {128{1'b1}});
    collect("sim_next", 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f ^ 128'hc0ffee00c0ffee00c0ffee00c0ffee00);

    // Reset asserted after two of four words have transferred
    offer(128'hdeadbeefcafebabe0badf00d8badf00d, 128'h77, 1'b0, 128'd0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_data", {96'd0, out_data}, 128'd0);
    chk("mid_rst_empty", {127'd0, dec_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_iv(128'd0);
    offer(128'hab54a98ceb1f0ad2a5f2c8e46b3d7f91, 128'h99, 1'b0, 128'd0);
    collect("post_rst", 128'hab54a98ceb1f0ad2a5f2c8e46b3d7f91);

`ifdef AES_UNCHAIN_ECB_EN
    // ECB bypass with a nonzero chain, then back to CBC
    offer(128'd0, 128'h5a5a5a5a00000000ffffffff12345678, 1'b0, 128'd0);
    collect("ecb_pre", 128'h99);
    ecb_mode = 1'b1;
    offer({16{8'ha5}}, 128'h0badc0de0badc0de0badc0de0badc0de, 1'b0, 128'd0);
    ecb_mode = 1'b0;
    offer(128'h11223344556677881122334455667788, 128'h1, 1'b0, 128'd0);
    collect("ecb_blk", {16{8'ha5}});
    collect("ecb_back_cbc", 128'h11223344556677881122334455667788 ^ 128'h0badc0de0badc0de0badc0de0badc0de);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
